// File: rtl/scariv_phy_regfile_banked.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scariv_phy_regfile_banked : banked physical register file, write-first
// bypass, bank-conflict arbitration and per-register ready tracking.
// Revision: 1.0
// ----------------------------------------------------------------------------
module scariv_phy_regfile_banked #(
  parameter string REG_TYPE        = "GPR",
  parameter int    RNID_SIZE       = 64,
  parameter int    WIDTH           = 64,
  parameter int    RD_PORT_SIZE    = 4,
  parameter int    WR_PORT_SIZE    = 2,
  parameter int    ALLOC_PORT_SIZE = 2,
  parameter int    BANK_NUM        = 2,
  parameter int    BANK_RD_PORTS   = 1,
  localparam int   RNID_W          = $clog2(RNID_SIZE)
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset_n,
  input  logic [RD_PORT_SIZE-1:0]                   i_rd_valid,
  input  logic [RD_PORT_SIZE-1:0][RNID_W-1:0]       i_rd_rnid,
  output logic [RD_PORT_SIZE-1:0]                   o_rd_resp,
  output logic [RD_PORT_SIZE-1:0]                   o_rd_conflict,
  output logic [RD_PORT_SIZE-1:0][WIDTH-1:0]        o_rd_data,
  input  logic [WR_PORT_SIZE-1:0]                   i_wr_valid,
  input  logic [WR_PORT_SIZE-1:0][RNID_W-1:0]       i_wr_rnid,
  input  logic [WR_PORT_SIZE-1:0][WIDTH-1:0]        i_wr_data,
  input  logic [ALLOC_PORT_SIZE-1:0]                i_alloc_valid,
  input  logic [ALLOC_PORT_SIZE-1:0][RNID_W-1:0]    i_alloc_rnid,
  output logic [RNID_SIZE-1:0]                      o_ready
);

  localparam bit c_is_gpr = (REG_TYPE == "GPR");
  localparam int c_bank_w = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int c_cnt_w  = $clog2(RD_PORT_SIZE + 1);
  localparam logic [c_cnt_w-1:0]  c_bank_rd_max = c_cnt_w'(BANK_RD_PORTS);
  localparam logic [RNID_W:0]     c_rnid_lim    = (RNID_W+1)'(RNID_SIZE);

  logic [WIDTH-1:0]                     r_array [RNID_SIZE];
  logic [RNID_SIZE-1:0]                 r_ready;
  logic [RD_PORT_SIZE-1:0]              r_rd_resp;
  logic [RD_PORT_SIZE-1:0]              r_rd_conflict;
  logic [RD_PORT_SIZE-1:0][WIDTH-1:0]   r_rd_data;

  logic [RD_PORT_SIZE-1:0]              w_rd_zero;
  logic [RD_PORT_SIZE-1:0]              w_rd_legal;
  logic [RD_PORT_SIZE-1:0][c_bank_w-1:0] w_rd_bank;
  logic [RD_PORT_SIZE-1:0]              w_rd_grant;
  logic [RD_PORT_SIZE-1:0]              w_rd_refuse;
  logic [c_cnt_w-1:0]                   w_bank_cnt [BANK_NUM];
  logic [RD_PORT_SIZE-1:0][WIDTH-1:0]   w_rd_data_next;
  logic [WR_PORT_SIZE-1:0]              w_wr_legal;
  logic [ALLOC_PORT_SIZE-1:0]           w_alloc_legal;
  logic [RNID_SIZE-1:0]                 w_wr_en;
  logic [WIDTH-1:0]                     w_wr_val [RNID_SIZE];
  logic [RNID_SIZE-1:0]                 w_alloc_hit;
  logic                                 w_wr_multi_hit;
  logic                                 w_any_oob;

  generate
    for (genvar p = 0; p < RD_PORT_SIZE; p++) begin : g_rd_decode
      assign w_rd_legal[p] = {1'b0, i_rd_rnid[p]} < c_rnid_lim;
      assign w_rd_zero[p]  = c_is_gpr && (i_rd_rnid[p] == '0);
      if (BANK_NUM > 1) begin : g_bank_bits
        assign w_rd_bank[p] = i_rd_rnid[p][c_bank_w-1:0];
      end else begin : g_bank_single
        assign w_rd_bank[p] = '0;
      end
    end
    for (genvar w = 0; w < WR_PORT_SIZE; w++) begin : g_wr_decode
      assign w_wr_legal[w] = {1'b0, i_wr_rnid[w]} < c_rnid_lim;
    end
    for (genvar a = 0; a < ALLOC_PORT_SIZE; a++) begin : g_alloc_decode
      assign w_alloc_legal[a] = {1'b0, i_alloc_rnid[a]} < c_rnid_lim;
    end
  endgenerate

  // Ascending-port arbitration; the zero register never takes a bank slot.
  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) w_bank_cnt[b] = '0;
    w_rd_grant  = '0;
    w_rd_refuse = '0;
    for (int p = 0; p < RD_PORT_SIZE; p++) begin
      if (i_rd_valid[p]) begin
        if (w_rd_zero[p]) begin
          w_rd_grant[p] = 1'b1;
        end else if (w_bank_cnt[w_rd_bank[p]] < c_bank_rd_max) begin
          w_rd_grant[p] = 1'b1;
          w_bank_cnt[w_rd_bank[p]] = w_bank_cnt[w_rd_bank[p]] + c_cnt_w'(1);
        end else begin
          w_rd_refuse[p] = 1'b1;
        end
      end
    end
  end

  // Write-first bypass: scan write ports downwards so the lowest index wins.
  always_comb begin
    for (int p = 0; p < RD_PORT_SIZE; p++) begin
      w_rd_data_next[p] = '0;
      if (w_rd_grant[p] && !w_rd_zero[p] && w_rd_legal[p]) begin
        w_rd_data_next[p] = r_array[i_rd_rnid[p]];
        for (int w = WR_PORT_SIZE - 1; w >= 0; w--) begin
          if (i_wr_valid[w] && (i_wr_rnid[w] == i_rd_rnid[p])) begin
            w_rd_data_next[p] = i_wr_data[w];
          end
        end
      end
    end
  end

  // Per-entry decode; out-of-range rnids match no entry and so touch nothing.
  always_comb begin
    w_wr_en     = '0;
    w_alloc_hit = '0;
    for (int e = 0; e < RNID_SIZE; e++) begin
      w_wr_val[e] = '0;
      for (int w = WR_PORT_SIZE - 1; w >= 0; w--) begin
        if (i_wr_valid[w] && (i_wr_rnid[w] == RNID_W'(e))) begin
          w_wr_en[e]  = 1'b1;
          w_wr_val[e] = i_wr_data[w];
        end
      end
      for (int a = 0; a < ALLOC_PORT_SIZE; a++) begin
        if (i_alloc_valid[a] && (i_alloc_rnid[a] == RNID_W'(e))) begin
          w_alloc_hit[e] = 1'b1;
        end
      end
    end
    if (c_is_gpr) begin
      w_wr_en[0]     = 1'b0;
      w_alloc_hit[0] = 1'b0;
    end
  end

  always_comb begin
    w_wr_multi_hit = 1'b0;
    for (int i = 0; i < WR_PORT_SIZE; i++) begin
      for (int j = i + 1; j < WR_PORT_SIZE; j++) begin
        if (i_wr_valid[i] && i_wr_valid[j] && (i_wr_rnid[i] == i_wr_rnid[j]) &&
            !(c_is_gpr && (i_wr_rnid[i] == '0))) begin
          w_wr_multi_hit = 1'b1;
        end
      end
    end
  end

  assign w_any_oob = |(i_rd_valid & ~w_rd_legal) | |(i_wr_valid & ~w_wr_legal) |
                     |(i_alloc_valid & ~w_alloc_legal);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int e = 0; e < RNID_SIZE; e++) r_array[e] <= '0;
    end else begin
      for (int e = 0; e < RNID_SIZE; e++) begin
        if (w_wr_en[e]) r_array[e] <= w_wr_val[e];
      end
    end
  end

  // Allocation beats a same-cycle write so the register reads as not ready.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ready <= '1;
    end else begin
      for (int e = 0; e < RNID_SIZE; e++) begin
        if (w_alloc_hit[e])  r_ready[e] <= 1'b0;
        else if (w_wr_en[e]) r_ready[e] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_resp     <= '0;
      r_rd_conflict <= '0;
      r_rd_data     <= '0;
    end else begin
      r_rd_resp     <= w_rd_grant;
      r_rd_conflict <= w_rd_refuse;
      r_rd_data     <= w_rd_data_next;
    end
  end

  assign o_rd_resp     = r_rd_resp;
  assign o_rd_conflict = r_rd_conflict;
  assign o_rd_data     = r_rd_data;
  assign o_ready       = r_ready;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      assert (!w_wr_multi_hit)
        else $warning("scariv_phy_regfile_banked: several write ports target one rnid; lowest port kept");
      assert (!w_any_oob)
        else $warning("scariv_phy_regfile_banked: rnid out of range");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scariv_phy_regfile_banked.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_scariv_phy_regfile_banked : directed scoreboard bench for the register file.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_scariv_phy_regfile_banked;

  localparam int RD = 4;
  localparam int WR = 2;
  localparam int AL = 2;
  localparam int N  = 64;
  localparam int RW = 6;
  localparam int W  = 64;

  logic                 i_clk = 1'b0;
  logic                 i_reset_n = 1'b0;
  logic [RD-1:0]        i_rd_valid;
  logic [RD-1:0][RW-1:0] i_rd_rnid;
  logic [RD-1:0]        o_rd_resp;
  logic [RD-1:0]        o_rd_conflict;
  logic [RD-1:0][W-1:0] o_rd_data;
  logic [WR-1:0]        i_wr_valid;
  logic [WR-1:0][RW-1:0] i_wr_rnid;
  logic [WR-1:0][W-1:0] i_wr_data;
  logic [AL-1:0]        i_alloc_valid;
  logic [AL-1:0][RW-1:0] i_alloc_rnid;
  logic [N-1:0]         o_ready;

  scariv_phy_regfile_banked dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rd_valid(i_rd_valid), .i_rd_rnid(i_rd_rnid),
    .o_rd_resp(o_rd_resp), .o_rd_conflict(o_rd_conflict), .o_rd_data(o_rd_data),
    .i_wr_valid(i_wr_valid), .i_wr_rnid(i_wr_rnid), .i_wr_data(i_wr_data),
    .i_alloc_valid(i_alloc_valid), .i_alloc_rnid(i_alloc_rnid),
    .o_ready(o_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         port;
    logic       resp;
    logic       conf;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_rd_valid = '0; i_rd_rnid = '0;
    i_wr_valid = '0; i_wr_rnid = '0; i_wr_data = '0;
    i_alloc_valid = '0; i_alloc_rnid = '0;
  endtask

  task automatic rd(input int p, input int rnid);
    i_rd_valid[p] = 1'b1;
    i_rd_rnid[p]  = RW'(rnid);
  endtask

  task automatic wr(input int p, input int rnid, input logic [W-1:0] d);
    i_wr_valid[p] = 1'b1;
    i_wr_rnid[p]  = RW'(rnid);
    i_wr_data[p]  = d;
  endtask

  task automatic alloc(input int p, input int rnid);
    i_alloc_valid[p] = 1'b1;
    i_alloc_rnid[p]  = RW'(rnid);
  endtask

  task automatic push(input int p, input logic resp, input logic conf, input logic [W-1:0] d);
    exp_t e;
    e.port = p; e.resp = resp; e.conf = conf; e.data = d;
    q.push_back(e);
  endtask

  // Advance one clock and retire every expectation queued for this cycle.
  task automatic tick();
    @(posedge i_clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("rd%0d_resp", e.port), 128'(o_rd_resp[e.port]), 128'(e.resp));
      check($sformatf("rd%0d_conflict", e.port), 128'(o_rd_conflict[e.port]), 128'(e.conf));
      check($sformatf("rd%0d_data", e.port), 128'(o_rd_data[e.port]), 128'(e.data));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_resp", 128'(o_rd_resp), 128'(0));
    check("rst_conflict", 128'(o_rd_conflict), 128'(0));
    check("rst_data", 128'(o_rd_data), 128'(0));
    check("rst_ready", 128'(o_ready), 128'({N{1'b1}}));
    i_reset_n = 1'b1;

    // Bypass of a same-cycle write, then the stored value
    idle(); wr(0, 5, 64'hAA); rd(0, 5);
    push(0, 1, 0, 64'hAA); push(1, 0, 0, 0); push(2, 0, 0, 0); push(3, 0, 0, 0);
    tick();
    check("ready5_after_wr", 128'(o_ready[5]), 128'(1));
    idle(); rd(0, 5); push(0, 1, 0, 64'hAA);
    tick();

    // Preload rnids 2, 4, 3
    idle(); wr(0, 2, 64'h1234); wr(1, 4, 64'h4444); tick();
    idle(); wr(0, 3, 64'h3333); tick();

    // Bank conflict: 2 and 4 share bank 0, 3 is in bank 1
    idle(); rd(0, 2); rd(1, 4); rd(2, 3);
    push(0, 1, 0, 64'h1234); push(1, 0, 1, 0); push(2, 1, 0, 64'h3333); push(3, 0, 0, 0);
    tick();
    idle(); rd(1, 4); push(1, 1, 0, 64'h4444); push(0, 0, 0, 0);
    tick();

    // Ready tracking
    idle(); alloc(0, 7);
    #1 check("ready7_same_cycle", 128'(o_ready[7]), 128'(1));
    tick();
    check("ready7_alloc", 128'(o_ready[7]), 128'(0));
    check("ready8_untouched", 128'(o_ready[8]), 128'(1));
    idle(); wr(0, 7, 64'h77); tick();
    check("ready7_write", 128'(o_ready[7]), 128'(1));
    idle(); alloc(1, 9); wr(1, 9, 64'h99); tick();
    check("ready9_alloc_wins", 128'(o_ready[9]), 128'(0));
    idle(); rd(2, 9); push(2, 1, 0, 64'h99); tick();

    // GPR zero register
    idle(); wr(0, 0, 64'hFF); tick();
    idle(); alloc(0, 0);
    for (int p = 0; p < RD; p++) begin
      rd(p, 0);
      push(p, 1, 0, 0);
    end
    tick();
    check("ready0_pinned", 128'(o_ready[0]), 128'(1));

    // Dual write to one rnid, lowest port wins both in bypass and array
    idle(); wr(0, 3, 64'h11); wr(1, 3, 64'h22); rd(0, 3);
    #1 check("multi_write_flag", 128'(dut.w_wr_multi_hit), 128'(1));
    push(0, 1, 0, 64'h11);
    tick();
    idle(); rd(3, 3); push(3, 1, 0, 64'h11); tick();

    // Reset while reads are in flight
    idle(); rd(0, 3); rd(1, 2); alloc(0, 10);
    push(0, 1, 0, 64'h11); push(1, 1, 0, 64'h1234);
    tick();
    #2 i_reset_n = 1'b0;
    #1;
    check("midrst_resp", 128'(o_rd_resp), 128'(0));
    check("midrst_data", 128'(o_rd_data), 128'(0));
    check("midrst_ready", 128'(o_ready), 128'({N{1'b1}}));
    @(posedge i_clk);
    @(negedge i_clk);
    idle(); i_reset_n = 1'b1;
    for (int p = 0; p < RD; p++) push(p, 0, 0, 0);
    tick();

    // Short reset pulse; the first cycle after release must be served
    i_reset_n = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(); rd(0, 3); rd(3, 4);
    push(0, 1, 0, 0); push(3, 1, 0, 0); push(1, 0, 0, 0);
    tick();
    check("post_rst_ready", 128'(o_ready), 128'({N{1'b1}}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scariv_phy_regfile_banked.md
SCARIV_PHY_REGFILE_BANKED -- requirements
Module: scariv_phy_regfile_banked

Interface
REQ-001 Parameters SHALL be:
- REG_TYPE, default GPR, selects GPR or FPR behaviour.
- RNID_SIZE, default 64, number of physical registers.
- WIDTH, default 64, data bits.
- RD_PORT_SIZE, default 4, read ports.
- WR_PORT_SIZE, default 2, write ports.
- ALLOC_PORT_SIZE, default 2, allocation ports.
- BANK_NUM, default 2 (power of two), read banks.
- BANK_RD_PORTS, default 1, reads per bank per cycle.
REQ-002 RNID_W SHALL be $clog2(RNID_SIZE).
REQ-003 Ports SHALL be as follows:
- i_clk  in  1  clock; rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rd_valid  in  [RD_PORT_SIZE]  read request.
- i_rd_rnid  in  [RD_PORT_SIZE][RNID_W]  read register.
- o_rd_resp  out  [RD_PORT_SIZE]  read data valid, one cycle after request.
- o_rd_conflict  out  [RD_PORT_SIZE]  bank conflict; requester retries.
- o_rd_data  out  [RD_PORT_SIZE][WIDTH]  read data.
- i_wr_valid  in  [WR_PORT_SIZE]  write request.
- i_wr_rnid  in  [WR_PORT_SIZE][RNID_W]  write register.
- i_wr_data  in  [WR_PORT_SIZE][WIDTH]  write data.
- i_alloc_valid  in  [ALLOC_PORT_SIZE]  rename allocation.
- i_alloc_rnid  in  [ALLOC_PORT_SIZE][RNID_W]  allocated register.
- o_ready  out  [RNID_SIZE]  per-register data-ready bit.

Function
REQ-004 The bank of a register SHALL be rnid[$clog2(BANK_NUM)-1:0].
REQ-005 Each cycle, valid reads to one bank SHALL be granted in ascending port index up to BANK_RD_PORTS.
REQ-006 Further reads to that bank in the same cycle SHALL be refused.
REQ-007 Read latency SHALL be exactly 1 cycle, registered:
- Granted read -> next cycle o_rd_resp=1, o_rd_conflict=0.
- Refused read -> next cycle o_rd_resp=0, o_rd_conflict=1.
- Invalid port -> next cycle both 0, o_rd_data=0.
REQ-008 A read SHALL bypass a same-cycle write to the same rnid and return the new data (write-first).
REQ-009 If several write ports hit the read's rnid, the lowest write port index SHALL supply the data.
REQ-010 For REG_TYPE==GPR, rnid 0 SHALL:
- read as 0,
- consume no bank slot,
- never conflict,
- ignore writes,
- have o_ready[0] permanently 1.
REQ-011 A valid write SHALL update the array at the clock edge.
REQ-012 When several write ports target one rnid in one cycle, the lowest index SHALL win; simulation SHALL flag this with an assertion.
REQ-013 A write SHALL set o_ready[rnid]=1 from the next cycle.
REQ-014 An allocation SHALL clear o_ready[rnid]=0 from the next cycle.
REQ-015 When an allocation and a write hit the same rnid in one cycle, the allocation SHALL win and ready SHALL end at 0; the data write still occurs.
REQ-016 o_ready SHALL be registered and SHALL NOT combinationally depend on same-cycle inputs.
REQ-017 rnid values >= RNID_SIZE are illegal and SHALL trigger a simulation assertion.
REQ-018 Out-of-range rnid values SHALL NOT corrupt any state.

Reset
REQ-019 On i_reset_n=0, asynchronously, the block SHALL:
- clear all array entries to 0,
- set all o_ready bits to 1,
- drive o_rd_resp, o_rd_conflict and o_rd_data to 0.
REQ-020 A read issued in the cycle reset asserts SHALL produce no response after reset release.
REQ-021 The first cycle after reset release SHALL accept requests normally.

Verification
REQ-022 Bypass:
- Cycle 0: write rnid 5 = 0xAA and read rnid 5 on port 0.
- Cycle 1: o_rd_resp[0]=1, data 0xAA.
- Cycle 2: read rnid 5 returns 0xAA from the array.
REQ-023 Bank conflict (BANK_NUM=2, BANK_RD_PORTS=1):
- Ports 0–2 read rnids 2, 4, 3.
- Next cycle: ports 0 and 2 have resp=1; port 1 has conflict=1.
- Port 1 retried alone on the next cycle -> resp=1.
REQ-024 Ready tracking:
- Allocate rnid 7 -> o_ready[7]=0 next cycle.
- Write rnid 7 -> o_ready[7]=1 next cycle.
- Allocate and write rnid 9 in one cycle -> o_ready[9]=0 and the data is stored.
REQ-025 GPR zero register:
- Write rnid 0 = 0xFF, then read rnid 0 on all ports.
- All ports return resp=1, data 0, conflict=0.
REQ-026 Dual write:
- Ports 0 and 1 write rnid 3 with 0x11 and 0x22.
- A later read returns 0x11; the simulation assertion fires.
REQ-027 Reset mid-operation:
- Assert reset while reads are in flight.
- Outputs go to 0 immediately.
- Reads after release return 0 and all o_ready bits are 1.
